// File: rtl/uart_32b_link.sv
// 8N1 UART link: byte receiver plus a transmitter that sends single bytes
// or 32-bit words as four back-to-back frames, least-significant byte first.
module uart_32b_link #(
   parameter int NB_DATA       = 32,
   parameter int NB_BYTE       = 8,
   parameter int CLKS_PER_TICK = 651
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx,
   input  logic [NB_DATA-1:0] i_tx_data,
   input  logic               i_tx_start_8b,
   input  logic               i_tx_start_32b,
   output logic               o_tx,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_tx_done_8b_pulse,
   output logic               o_tx_done_32b_pulse,
   output logic               o_rx_done_pulse
);

   localparam int NB_TCNT =
      (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam int NB_BIDX = $clog2(NB_BYTE);
   localparam int N_BYTES = NB_DATA / NB_BYTE;
   localparam int NB_WIDX = $clog2(N_BYTES);

   localparam logic [NB_TCNT-1:0] TICK_MAX =
      NB_TCNT'(CLKS_PER_TICK - 1);
   localparam logic [NB_BIDX-1:0] BIT_LAST =
      NB_BIDX'(NB_BYTE - 1);
   localparam logic [NB_WIDX-1:0] BYTE_LAST =
      NB_WIDX'(N_BYTES - 1);
   localparam logic [3:0] TICK_LAST = 4'd15;
   localparam logic [3:0] TICK_MID  = 4'd7;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_NEXT
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // ---------------- shared baud tick ----------------
   logic [NB_TCNT-1:0] r_tick_cnt;
   logic               w_tick;

   assign w_tick = (r_tick_cnt == TICK_MAX);

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_tick_cnt <= '0;
      else if (w_tick)
         r_tick_cnt <= '0;
      else
         r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   // ---------------- transmitter ----------------
   tx_state_t          r_tx_state;
   tx_state_t          w_tx_state_nxt;
   logic [3:0]         r_tx_tcnt;
   logic [NB_BIDX-1:0] r_tx_bit;
   logic [NB_WIDX-1:0] r_tx_byte;
   logic [NB_DATA-1:0] r_tx_word;
   logic [NB_BYTE-1:0] r_tx_shift;
   logic               r_tx_wmode;
   logic               r_tx;
   logic               r_done8;
   logic               r_done32;

   logic w_tx_bit_end;
   logic w_tx_line;
   logic w_load32;
   logic w_load8;
   logic w_shift_bit;
   logic w_next_byte;
   logic w_end8;
   logic w_end32;

   assign w_tx_bit_end = w_tick && (r_tx_tcnt == TICK_LAST);

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_tx_state <= TX_IDLE;
      else
         r_tx_state <= w_tx_state_nxt;
   end

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_line      = 1'b1;
      w_load32       = 1'b0;
      w_load8        = 1'b0;
      w_shift_bit    = 1'b0;
      w_next_byte    = 1'b0;
      w_end8         = 1'b0;
      w_end32        = 1'b0;
      unique case (r_tx_state)
         TX_IDLE: begin
            if (i_tx_start_32b) begin
               w_load32       = 1'b1;
               w_tx_state_nxt = TX_START;
            end else if (i_tx_start_8b) begin
               w_load8        = 1'b1;
               w_tx_state_nxt = TX_START;
            end
         end
         TX_START: begin
            w_tx_line = 1'b0;
            if (w_tx_bit_end)
               w_tx_state_nxt = TX_DATA;
         end
         TX_DATA: begin
            w_tx_line = r_tx_shift[0];
            if (w_tx_bit_end) begin
               w_shift_bit = 1'b1;
               if (r_tx_bit == BIT_LAST)
                  w_tx_state_nxt = TX_STOP;
            end
         end
         TX_STOP: begin
            if (w_tx_bit_end) begin
               w_end8 = 1'b1;
               if (r_tx_wmode && (r_tx_byte != BYTE_LAST)) begin
                  w_tx_state_nxt = TX_NEXT;
               end else begin
                  w_end32        = r_tx_wmode;
                  w_tx_state_nxt = TX_IDLE;
               end
            end
         end
         TX_NEXT: begin
            // line already drops here so consecutive frames have no gap
            w_tx_line      = 1'b0;
            w_next_byte    = 1'b1;
            w_tx_state_nxt = TX_START;
         end
         default: w_tx_state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_tx       <= 1'b1;
         r_done8    <= 1'b0;
         r_done32   <= 1'b0;
         r_tx_tcnt  <= '0;
         r_tx_bit   <= '0;
         r_tx_byte  <= '0;
         r_tx_word  <= '0;
         r_tx_shift <= '0;
         r_tx_wmode <= 1'b0;
      end else begin
         r_tx     <= w_tx_line;
         r_done8  <= w_end8;
         r_done32 <= w_end32;
         if (r_tx_state == TX_IDLE || r_tx_state == TX_NEXT)
            r_tx_tcnt <= '0;
         else if (w_tick)
            r_tx_tcnt <= r_tx_tcnt + 1'b1;
         if (w_load32) begin
            r_tx_word  <= i_tx_data;
            r_tx_shift <= i_tx_data[NB_BYTE-1:0];
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx_wmode <= 1'b1;
         end else if (w_load8) begin
            r_tx_shift <= i_tx_data[NB_BYTE-1:0];
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx_wmode <= 1'b0;
         end else if (w_shift_bit) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 1'b1;
         end else if (w_next_byte) begin
            r_tx_word  <= r_tx_word >> NB_BYTE;
            r_tx_shift <= r_tx_word[2*NB_BYTE-1:NB_BYTE];
            r_tx_bit   <= '0;
            r_tx_byte  <= r_tx_byte + 1'b1;
         end
      end
   end

   assign o_tx                = r_tx;
   assign o_tx_done_8b_pulse  = r_done8;
   assign o_tx_done_32b_pulse = r_done32;

   // ---------------- receiver ----------------
   logic               r_rx_meta;
   logic               r_rx_sync;
   rx_state_t          r_rx_state;
   rx_state_t          w_rx_state_nxt;
   logic [3:0]         r_rx_tcnt;
   logic [NB_BIDX-1:0] r_rx_bit;
   logic [NB_BYTE-1:0] r_rx_shift;
   logic [NB_DATA-1:0] r_data;
   logic               r_rx_done;

   logic w_rx_clr;
   logic w_rx_sample;
   logic w_rx_accept;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_rx_state <= RX_IDLE;
      else
         r_rx_state <= w_rx_state_nxt;
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_clr       = 1'b0;
      w_rx_sample    = 1'b0;
      w_rx_accept    = 1'b0;
      unique case (r_rx_state)
         RX_IDLE: begin
            w_rx_clr = 1'b1;
            if (!r_rx_sync)
               w_rx_state_nxt = RX_START;
         end
         RX_START: begin
            // mid start bit: a high line here means it was a glitch
            if (w_tick && (r_rx_tcnt == TICK_MID)) begin
               w_rx_clr       = 1'b1;
               w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (w_tick && (r_rx_tcnt == TICK_LAST)) begin
               w_rx_sample = 1'b1;
               if (r_rx_bit == BIT_LAST)
                  w_rx_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (w_tick && (r_rx_tcnt == TICK_LAST)) begin
               w_rx_accept    = r_rx_sync;
               w_rx_state_nxt = RX_IDLE;
            end
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rx_tcnt  <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_data     <= '0;
         r_rx_done  <= 1'b0;
      end else begin
         r_rx_done <= w_rx_accept;
         if (w_rx_clr)
            r_rx_tcnt <= '0;
         else if (w_tick)
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
         if (r_rx_state == RX_IDLE)
            r_rx_bit <= '0;
         else if (w_rx_sample)
            r_rx_bit <= r_rx_bit + 1'b1;
         if (w_rx_sample)
            r_rx_shift <= {r_rx_sync, r_rx_shift[NB_BYTE-1:1]};
         if (w_rx_accept)
            r_data <= {{(NB_DATA-NB_BYTE){1'b0}}, r_rx_shift};
      end
   end

   assign o_data          = r_data;
   assign o_rx_done_pulse = r_rx_done;

endmodule

// File: tb/tb_uart_32b_link.sv
// Bench for uart_32b_link: vector table for TX sends, scoreboards for
// TX bytes and RX words, hand sequences for reset, glitch and framing.
module tb_uart_32b_link;

   localparam int CPT      = 4;
   localparam int BIT_CLKS = 16 * CPT;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [31:0] txd;
   logic        s8;
   logic        s32;
   logic        o_tx;
   logic [31:0] o_data;
   logic        done8;
   logic        done32;
   logic        rxdone;

   always #5 clk = ~clk;

   uart_32b_link #(
      .NB_DATA      (32),
      .NB_BYTE      (8),
      .CLKS_PER_TICK(CPT)
   ) dut (
      .i_clock            (clk),
      .i_reset            (rst),
      .i_rx               (rx),
      .i_tx_data          (txd),
      .i_tx_start_8b      (s8),
      .i_tx_start_32b     (s32),
      .o_tx               (o_tx),
      .o_data             (o_data),
      .o_tx_done_8b_pulse (done8),
      .o_tx_done_32b_pulse(done32),
      .o_rx_done_pulse    (rxdone)
   );

   typedef struct {
      logic [1:0]  mode;   // bit0: 8b start, bit1: 32b start
      logic [31:0] data;
      int          nbytes;
      logic [31:0] exp;    // expected bytes, first in [7:0]
      int          n32;
      bit          busy;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int cnt8     = 0;
   int cnt32    = 0;
   int cntrx    = 0;

   logic [7:0]  tx_q[$];
   logic [31:0] rx_q[$];
   vec_t        tbl[7];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] m,
                               input logic [31:0] d,
                               input int n,
                               input logic [31:0] e,
                               input int n32,
                               input bit busy);
      vec_t v;
      v.mode = m; v.data = d; v.nbytes = n;
      v.exp = e; v.n32 = n32; v.busy = busy;
      return v;
   endfunction

   always @(negedge clk) begin
      if (done8 === 1'b1) cnt8++;
      if (done32 === 1'b1) begin
         cnt32++;
         chk("done32_with_done8", {31'b0, done8}, 32'd1);
      end
      if (rxdone === 1'b1) begin
         cntrx++;
         if (rx_q.size() == 0)
            chk("rx_unexpected_pulse", {31'b0, rxdone}, 32'd0);
         else
            chk("rx_data", o_data, rx_q.pop_front());
      end
   end

   task automatic get_frame(output logic [7:0] b, output logic ok);
      int n = 0;
      ok = 1'b1;
      b  = 'x;
      while (o_tx !== 1'b0 && n < 20 * BIT_CLKS) begin
         @(negedge clk);
         n++;
      end
      if (o_tx !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      repeat (BIT_CLKS / 2) @(negedge clk);
      if (o_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (BIT_CLKS) @(negedge clk);
         b[i] = o_tx;
      end
      repeat (BIT_CLKS) @(negedge clk);
      if (o_tx !== 1'b1) ok = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int c8  = cnt8;
      int c32 = cnt32;
      logic [7:0] b;
      logic       ok;
      @(negedge clk);
      txd = v.data;
      s8  = v.mode[0];
      s32 = v.mode[1];
      for (int k = 0; k < v.nbytes; k++)
         tx_q.push_back(v.exp[8*k +: 8]);
      @(negedge clk);
      s8  = 1'b0;
      s32 = 1'b0;
      txd = 32'hDEADBEEF;
      chk($sformatf("v%0d_tx_high_at_accept", idx), {31'b0, o_tx}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_start_latency", idx), {31'b0, o_tx}, 32'd0);
      for (int k = 0; k < v.nbytes; k++) begin
         get_frame(b, ok);
         chk($sformatf("v%0d_frame%0d_ok", idx, k), {31'b0, ok}, 32'd1);
         chk($sformatf("v%0d_byte%0d", idx, k), {24'b0, b},
             {24'b0, tx_q.pop_front()});
         if (v.busy && k == 0) begin
            @(negedge clk);
            s8  = 1'b1;
            s32 = 1'b1;
            txd = 32'h11223344;
            @(negedge clk);
            s8  = 1'b0;
            s32 = 1'b0;
         end
      end
      repeat (BIT_CLKS) @(negedge clk);
      chk($sformatf("v%0d_n8", idx), cnt8 - c8, v.nbytes);
      chk($sformatf("v%0d_n32", idx), cnt32 - c32, v.n32);
      chk($sformatf("v%0d_idle", idx), {31'b0, o_tx}, 32'd1);
   endtask

   task automatic send_rx(input logic [7:0] b,
                          input logic stop,
                          input int stop_ticks);
      @(negedge clk);
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = stop;
      repeat (stop_ticks * CPT) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      int c8;
      int c32;
      int crx;
      logic [7:0] b;
      logic       ok;

      tbl[0] = mk(2'b10, 32'hAABBCCDD, 4, 32'hAABBCCDD, 1, 1'b0);
      tbl[1] = mk(2'b01, 32'h12345678, 1, 32'h00000078, 0, 1'b0);
      tbl[2] = mk(2'b11, 32'h01020304, 4, 32'h01020304, 1, 1'b0);
      tbl[3] = mk(2'b01, 32'hFFFFFF00, 1, 32'h00000000, 0, 1'b0);
      tbl[4] = mk(2'b01, 32'h000000FF, 1, 32'h000000FF, 0, 1'b0);
      tbl[5] = mk(2'b10, 32'h807E5501, 4, 32'h807E5501, 1, 1'b0);
      tbl[6] = mk(2'b10, 32'hAABBCCDD, 4, 32'hAABBCCDD, 1, 1'b1);

      rst = 1'b1;
      rx  = 1'b1;
      txd = '0;
      s8  = 1'b0;
      s32 = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      chk("rst_tx", {31'b0, o_tx}, 32'd1);
      chk("rst_data", o_data, 32'd0);
      chk("rst_pulses", {29'b0, done8, done32, rxdone}, 32'd0);
      lows = 0;
      repeat (10000) begin
         @(negedge clk);
         if (o_tx !== 1'b1) lows++;
      end
      chk("rst_idle_low_samples", lows, 0);
      chk("rst_no_pulses", cnt8 + cnt32 + cntrx, 0);

      for (int i = 0; i < 7; i++)
         run_vec(i, tbl[i]);

      crx = cntrx;
      rx_q.push_back(32'h000000A5);
      send_rx(8'hA5, 1'b1, 16);
      chk("rx_a5_pulses", cntrx - crx, 1);
      chk("rx_a5_data", o_data, 32'h000000A5);
      crx = cntrx;
      send_rx(8'h3C, 1'b0, 12);
      chk("rx_frame_err_pulses", cntrx - crx, 0);
      chk("rx_frame_err_data", o_data, 32'h000000A5);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPT) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT_CLKS) @(negedge clk);
      chk("rx_glitch_pulses", cntrx - crx, 0);
      chk("rx_glitch_data", o_data, 32'h000000A5);
      rx_q.push_back(32'h0000005A);
      send_rx(8'h5A, 1'b1, 16);
      chk("rx_5a_pulses", cntrx - crx, 1);

      @(negedge clk);
      txd = 32'hCAFEF00D;
      s32 = 1'b1;
      tx_q.push_back(8'h0D);
      tx_q.push_back(8'hF0);
      @(negedge clk);
      s32 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         get_frame(b, ok);
         chk($sformatf("mid_rst_frame%0d_ok", k), {31'b0, ok}, 32'd1);
         chk($sformatf("mid_rst_byte%0d", k), {24'b0, b},
             {24'b0, tx_q.pop_front()});
      end
      repeat (3 * BIT_CLKS) @(negedge clk);
      c8  = cnt8;
      c32 = cnt32;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_tx_high", {31'b0, o_tx}, 32'd1);
      rst = 1'b0;
      lows = 0;
      repeat (1000) begin
         @(negedge clk);
         if (o_tx !== 1'b1) lows++;
      end
      chk("mid_rst_low_samples", lows, 0);
      chk("mid_rst_no_done8", cnt8 - c8, 0);
      chk("mid_rst_no_done32", cnt32 - c32, 0);
      run_vec(7, mk(2'b01, 32'h0000003C, 1, 32'h0000003C, 0, 1'b0));

      chk("rx_queue_empty", rx_q.size(), 0);
      chk("tx_queue_empty", tx_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
